alu_hs_core: RTL and testbench

- Parametrised successor to the four-unit registered ALU, with one unified result bus.
- Adds a valid/ready handshake on input and output, an iterative restoring divider, output hold under backpressure, and divide-by-zero detection.
- Sits between the instruction decode stage and the writeback stage.
- Decodes ALU_FUN internally; there are no separate per-unit enables.

---
 rtl/alu_hs_core.sv | 140 ++++++++++++++
 tb/tb_alu_hs_core.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_hs_core.sv
// alu_hs_core: handshaked ALU with one unified result bus and an iterative restoring divider.
// One-cycle ops complete in a single edge; DIV with a non-zero divisor takes WIDTH cycles.
module alu_hs_core #(
    parameter int WIDTH  = 16,
    parameter bit DIV_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [2*WIDTH-1:0] RESULT,
    output logic [1:0]         OUT_CLASS,
    output logic               ZERO_FLAG,
    output logic               CARRY_FLAG,
    output logic               DIV_ERR,
    output logic               BUSY
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIV_BUSY, HOLD} state_t;

    state_t             state, state_nx;
    logic               accept, div_start, load_fast, load_div;
    logic [2*WIDTH-1:0] fast_res;
    logic [1:0]         fast_class;
    logic               fast_carry, fast_err;
    logic [WIDTH:0]     sum, diff, partial, trial;
    logic [WIDTH-1:0]   dvd, dvs, rem, rem_nx, quo_nx;
    logic               take;
    logic [CW-1:0]      count;

    assign OUT_VALID = state == HOLD;
    assign BUSY      = state == DIV_BUSY;

    always_comb begin
        IN_READY  = state == IDLE || (state == HOLD && OUT_READY);
        accept    = IN_VALID && IN_READY;
        div_start = accept && DIV_EN && ALU_FUN == 4'd3 && B != '0;
        load_fast = accept && !div_start;
        load_div  = state == DIV_BUSY && count == CW'(1);
        state_nx  = state;
        if (div_start)
            state_nx = DIV_BUSY;
        else if (load_fast || load_div)
            state_nx = HOLD;
        else if (state == HOLD && OUT_READY)
            state_nx = IDLE;
    end

    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= IDLE;
        else      state <= state_nx;

    // Restoring step: the sign of the trial subtraction decides the quotient bit.
    always_comb begin
        partial = {rem, dvd[WIDTH-1]};
        trial   = partial - {1'b0, dvs};
        take    = !trial[WIDTH];
        rem_nx  = take ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_nx  = {dvd[WIDTH-2:0], take};
    end

    always_comb begin
        sum        = {1'b0, A} + {1'b0, B};
        diff       = {1'b0, A} - {1'b0, B};
        fast_res   = '0;
        fast_carry = 1'b0;
        fast_err   = 1'b0;
        case (ALU_FUN)
            4'd0: begin
                fast_res   = {{(WIDTH-1){1'b0}}, sum};
                fast_carry = sum[WIDTH];
            end
            4'd1: begin
                fast_res   = {{(WIDTH-1){1'b0}}, diff};
                fast_carry = diff[WIDTH];
            end
            4'd2: fast_res = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
            4'd3: begin
                fast_res = DIV_EN ? {A, {WIDTH{1'b1}}} : '0;
                fast_err = 1'b1;
            end
            4'd4:  fast_res = {{WIDTH{1'b0}}, A & B};
            4'd5:  fast_res = {{WIDTH{1'b0}}, A | B};
            4'd6:  fast_res = {{WIDTH{1'b0}}, ~(A & B)};
            4'd7:  fast_res = {{WIDTH{1'b0}}, ~(A | B)};
            4'd8:  fast_res = {{WIDTH{1'b0}}, A ^ B};
            4'd9:  fast_res = {{WIDTH{1'b0}}, ~(A ^ B)};
            4'd10: fast_res = {{(2*WIDTH-1){1'b0}}, A == B};
            4'd11: fast_res = {{(2*WIDTH-1){1'b0}}, A > B};
            4'd12: fast_res = {{(2*WIDTH-1){1'b0}}, A < B};
            4'd13: fast_res = {{WIDTH{1'b0}}, A >> 1};
            4'd14: fast_res = {{WIDTH{1'b0}}, A << 1};
            4'd15: fast_res = {{WIDTH{1'b0}}, A[WIDTH-1], A[WIDTH-1:1]};
        endcase
        fast_class = ALU_FUN < 4'd4 ? 2'd0 : ALU_FUN < 4'd10 ? 2'd1 : ALU_FUN < 4'd13 ? 2'd2 : 2'd3;
    end

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            RESULT     <= '0;
            OUT_CLASS  <= '0;
            ZERO_FLAG  <= 1'b0;
            CARRY_FLAG <= 1'b0;
            DIV_ERR    <= 1'b0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            count      <= '0;
        end else begin
            if (div_start) begin
                dvd   <= A;
                dvs   <= B;
                rem   <= '0;
                count <= CW'(WIDTH);
            end else if (state == DIV_BUSY) begin
                dvd   <= quo_nx;
                rem   <= rem_nx;
                count <= count - CW'(1);
            end
            if (load_fast) begin
                RESULT     <= fast_res;
                OUT_CLASS  <= fast_class;
                ZERO_FLAG  <= fast_res == '0;
                CARRY_FLAG <= fast_carry;
                DIV_ERR    <= fast_err;
            end else if (load_div) begin
                RESULT     <= {rem_nx, quo_nx};
                OUT_CLASS  <= 2'd0;
                ZERO_FLAG  <= {rem_nx, quo_nx} == '0;
                CARRY_FLAG <= 1'b0;
                DIV_ERR    <= 1'b0;
            end
        end
endmodule

// File: tb/tb_alu_hs_core.sv
// tb_alu_hs_core: directed scenarios plus randomized traffic checked against an arithmetic model.
module tb_alu_hs_core;
    localparam int W = 16;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  cls;
        logic        zero;
        logic        carry;
        logic        err;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST, IN_VALID, OUT_READY;
    logic [W-1:0]  A, B;
    logic [3:0]    ALU_FUN;
    logic          IN_READY, OUT_VALID, ZERO_FLAG, CARRY_FLAG, DIV_ERR, BUSY;
    logic [2*W-1:0] RESULT;
    logic [1:0]    OUT_CLASS;
    int            checks = 0;
    int            errors = 0;

    alu_hs_core #(.WIDTH(W), .DIV_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RESULT(RESULT), .OUT_CLASS(OUT_CLASS), .ZERO_FLAG(ZERO_FLAG),
        .CARRY_FLAG(CARRY_FLAG), .DIV_ERR(DIV_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [37:0] obs();
        return {OUT_VALID, RESULT, OUT_CLASS, ZERO_FLAG, CARRY_FLAG, DIV_ERR};
    endfunction

    // Reference: straight from the opcode table, using host arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [31:0] ua, ub;
        logic [15:0] q, r;
        ua = {16'h0, a};
        ub = {16'h0, b};
        e = '0;
        if (op == 0) begin
            e.res = ua + ub;
            e.carry = (ua + ub) > 32'hFFFF;
        end else if (op == 1) begin
            e.res = {15'h0, a < b, a - b};
            e.carry = a < b;
        end else if (op == 2) e.res = ua * ub;
        else if (op == 3) begin
            if (b == 0) begin
                e.res = {a, 16'hFFFF};
                e.err = 1'b1;
            end else begin
                q = a / b;
                r = a % b;
                e.res = {r, q};
            end
        end
        else if (op == 4)  e.res = {16'h0, a & b};
        else if (op == 5)  e.res = {16'h0, a | b};
        else if (op == 6)  e.res = {16'h0, ~(a & b)};
        else if (op == 7)  e.res = {16'h0, ~(a | b)};
        else if (op == 8)  e.res = {16'h0, a ^ b};
        else if (op == 9)  e.res = {16'h0, ~(a ^ b)};
        else if (op == 10) e.res = (a == b) ? 1 : 0;
        else if (op == 11) e.res = (a > b) ? 1 : 0;
        else if (op == 12) e.res = (a < b) ? 1 : 0;
        else if (op == 13) e.res = ua / 2;
        else if (op == 14) e.res = (ua * 2) % 32'h10000;
        else               e.res = ua / 2 + (a >= 16'h8000 ? 32'h8000 : 0);
        e.cls = op <= 3 ? 2'd0 : op <= 9 ? 2'd1 : op <= 12 ? 2'd2 : 2'd3;
        e.zero = e.res == 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        IN_VALID = 1'b1;
        ALU_FUN = op;
        A = a;
        B = b;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        drive(4'd0, 16'h0, 16'h0);
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({obs(), BUSY, IN_READY} !== {38'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", {obs(), BUSY, IN_READY}, {38'h0, 1'b0, 1'b1});
        end
        RST = 1'b1;
        tick();
        checks++;
        if ({OUT_VALID, BUSY, IN_READY} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release got=%b want=001", {OUT_VALID, BUSY, IN_READY});
        end
    endtask

    task automatic test_arith_back_to_back();
        OUT_READY = 1'b1;
        drive(4'd0, 16'hFFFF, 16'h0001);
        tick();
        checks++;
        if (obs() !== {1'b1, 32'h0001_0000, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_carry got=%h want=%h", obs(), {1'b1, 32'h0001_0000, 2'd0, 1'b0, 1'b1, 1'b0});
        end
        drive(4'd1, 16'h0003, 16'h0005);
        tick();
        checks++;
        if (obs() !== {1'b1, 32'h0001_FFFE, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow got=%h want=%h", obs(), {1'b1, 32'h0001_FFFE, 2'd0, 1'b0, 1'b1, 1'b0});
        end
        drive(4'd2, 16'hFFFF, 16'hFFFF);
        tick();
        checks++;
        if (obs() !== {1'b1, 32'hFFFE_0001, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul_no_bubble got=%h want=%h", obs(), {1'b1, 32'hFFFE_0001, 2'd0, 1'b0, 1'b0, 1'b0});
        end
        IN_VALID = 1'b0;
        tick();
        checks++;
        if ({OUT_VALID, IN_READY} !== 2'b01) begin
            errors++;
            $display("FAIL drain_to_idle got=%b want=01", {OUT_VALID, IN_READY});
        end
    endtask

    task automatic test_div();
        int bad = 0;
        OUT_READY = 1'b1;
        drive(4'd3, 16'd100, 16'd7);
        tick();
        IN_VALID = 1'b0;
        for (int i = 0; i < W; i++) begin
            if ({BUSY, IN_READY, OUT_VALID} !== 3'b100) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_busy_window got=%0d bad cycles want=0", bad);
        end
        checks++;
        if ({obs(), BUSY} !== {1'b1, 32'h0002_000E, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL div_100_7 got=%h want=%h", {obs(), BUSY}, {1'b1, 32'h0002_000E, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        drive(4'd3, 16'h1234, 16'h0000);
        tick();
        checks++;
        if ({obs(), BUSY} !== {1'b1, 32'h1234_FFFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL div_by_zero got=%h want=%h", {obs(), BUSY}, {1'b1, 32'h1234_FFFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        OUT_READY = 1'b0;
        drive(4'd8, 16'hF0F0, 16'hFFFF);
        tick();
        drive(4'd10, 16'd5, 16'd5);
        for (int i = 0; i < 5; i++) begin
            if ({obs(), IN_READY} !== {1'b1, 32'h0000_0F0F, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0}) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL xor_hold got=%0d bad cycles want=0", bad);
        end
        OUT_READY = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready got=%b want=1", IN_READY);
        end
        tick();
        checks++;
        if (obs() !== {1'b1, 32'h0000_0001, 2'd2, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL eq_after_hold got=%h want=%h", obs(), {1'b1, 32'h0000_0001, 2'd2, 1'b0, 1'b0, 1'b0});
        end
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic test_shift_and();
        logic [15:0] want [3];
        want[0] = 16'h4000;
        want[1] = 16'h0002;
        want[2] = 16'hC000;
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'(13 + i), 16'h8001, 16'h0);
            tick();
            checks++;
            if (obs() !== {1'b1, 16'h0, want[i], 2'd3, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL shift_op%0d got=%h want=%h", 13 + i, obs(), {1'b1, 16'h0, want[i], 2'd3, 1'b0, 1'b0, 1'b0});
            end
        end
        drive(4'd4, 16'h00FF, 16'hFF00);
        tick();
        checks++;
        if (obs() !== {1'b1, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL and_zero got=%h want=%h", obs(), {1'b1, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0});
        end
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_div();
        int bad = 0;
        OUT_READY = 1'b1;
        drive(4'd0, 16'h1111, 16'h2222);
        tick();
        drive(4'd3, 16'hBEEF, 16'h0013);
        tick();
        IN_VALID = 1'b0;
        repeat (8) tick();
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL mid_div_busy got=%b want=1", BUSY);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({obs(), BUSY} !== 39'h0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", {obs(), BUSY});
        end
        tick();
        RST = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b want=1", IN_READY);
        end
        for (int i = 0; i < 2 * W; i++) begin
            if ({OUT_VALID, BUSY} !== 2'b00) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stale_output got=%0d bad cycles want=0", bad);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int done = 0;
        int cyc = 0;
        logic acc, take;
        drive(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        while ((done < 300 || q.size() != 0) && cyc < 20000) begin
            OUT_READY = $urandom_range(0, 3) != 0;
            #1;
            acc = IN_VALID && IN_READY;
            take = OUT_VALID && OUT_READY;
            if (take) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL random_spurious got=%h want=no output", obs());
                end else begin
                    e = q.pop_front();
                    if ({RESULT, OUT_CLASS, ZERO_FLAG, CARRY_FLAG, DIV_ERR} !== e) begin
                        errors++;
                        $display("FAIL random_result got=%h want=%h", {RESULT, OUT_CLASS, ZERO_FLAG, CARRY_FLAG, DIV_ERR}, e);
                    end
                end
            end
            if (acc) begin
                q.push_back(model(ALU_FUN, A, B));
                done++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (done < 300) begin
                    drive(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
                    if ($urandom_range(0, 7) == 0) B = 16'h0;
                    else if ($urandom_range(0, 7) == 0) B = A;
                    IN_VALID = $urandom_range(0, 4) != 0;
                end else IN_VALID = 1'b0;
            end else if (done < 300) IN_VALID = 1'b1;
        end
        checks++;
        if (cyc >= 20000) begin
            errors++;
            $display("FAIL random_timeout got=%0d done, %0d pending want=300 done, 0 pending", done, q.size());
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_arith_back_to_back();
        test_div();
        test_backpressure();
        test_shift_and();
        test_random();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
